line_animator_multi: RTL and testbench

Parametrised multi-line animator that sequences one `line_drawer` to animate `NUM_LINES` parallel line segments. On each update, it erases every line at the current step and redraws every line translated by `(DX, DY)`. After `STEPS` updates it wraps back to step 0. It sits between the frame-tick source and the VGA framebuffer write port, and adds `pixel_valid`, a one-cycle `frame_done` pulse, update queuing and a pause (`enable`) input.

---
 rtl/line_anim_pkg.sv | 34 +++
 rtl/line_animator_multi_line_drawer.sv | 82 ++++++++
 rtl/line_animator_multi.sv | 154 +++++++++++++++
 tb/tb_line_animator_multi.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/line_anim_pkg.sv
// rtl/line_anim_pkg.sv - shared types and endpoint arithmetic for line_animator_multi
// Contents:
//   state_t     : sequencer state (S_LOAD, S_RUN, S_WAIT)
//   phase_t     : current pass over the lines (PH_DRAW, PH_ERASE)
//   line_coord  : one endpoint coordinate for line i at step s, in 32 bits;
//                 callers truncate the result to their coordinate width.
package line_anim_pkg;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        PH_DRAW  = 1'b0,
        PH_ERASE = 1'b1
    } phase_t;

    // base + i*space + s*delta + len, wrapping modulo 2^32.
    // Truncating the result to COORD_W bits gives the same value as doing
    // the whole sum modulo 2^COORD_W.
    function automatic logic [31:0] line_coord(
        input logic [31:0] i,
        input logic [31:0] s,
        input logic [31:0] base,
        input logic [31:0] space,
        input logic [31:0] delta,
        input logic [31:0] len
    );
        return base + i * space + s * delta + len;
    endfunction

endpackage

// File: rtl/line_animator_multi_line_drawer.sv
// rtl/line_animator_multi_line_drawer.sv - Bresenham line walker, one pixel per clock
// Ports:
//   clk              : clock
//   reset            : synchronous, active-high; loads the endpoints and
//                      restarts the walk at (x0, y0)
//   x0, y0, x1, y1   : line endpoints, sampled while reset is high
//   x, y             : current pixel
//   finished         : high while the current pixel is the endpoint (x1, y1);
//                      the walker holds there until the next reset
module line_drawer #(
    parameter int COORD_W = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               finished
);

    // The error term stays within +/-2^(COORD_W+1); doubling it needs one
    // more bit, and one more bit keeps the sign.
    localparam int EW = COORD_W + 4;

    logic [COORD_W-1:0]   x_q, y_q, x1_q, y1_q;
    logic signed [EW-1:0] err_q, dx_q, dy_q;
    logic                 sx_neg_q, sy_neg_q;

    logic [COORD_W-1:0]   adx, ady;
    logic signed [EW-1:0] dx_in, dy_in, e2, err_d;
    logic                 step_x, step_y;
    logic [COORD_W-1:0]   x_d, y_d;

    assign adx   = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    assign ady   = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
    assign dx_in = $signed({4'b0000, adx});
    assign dy_in = -$signed({4'b0000, ady});

    assign finished = (x_q == x1_q) && (y_q == y1_q);

    always_comb begin
        e2     = err_q <<< 1;
        step_x = (e2 >= dy_q);
        step_y = (e2 <= dx_q);
        err_d  = err_q;
        x_d    = x_q;
        y_d    = y_q;
        if (step_x) begin
            err_d = err_d + dy_q;
            x_d   = sx_neg_q ? (x_q - COORD_W'(1)) : (x_q + COORD_W'(1));
        end
        if (step_y) begin
            err_d = err_d + dx_q;
            y_d   = sy_neg_q ? (y_q - COORD_W'(1)) : (y_q + COORD_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q      <= x0;
            y_q      <= y0;
            x1_q     <= x1;
            y1_q     <= y1;
            dx_q     <= dx_in;
            dy_q     <= dy_in;
            err_q    <= dx_in + dy_in;
            sx_neg_q <= (x1 < x0);
            sy_neg_q <= (y1 < y0);
        end else if (!finished) begin
            x_q   <= x_d;
            y_q   <= y_d;
            err_q <= err_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/line_animator_multi.sv
// rtl/line_animator_multi.sv - animates NUM_LINES parallel segments through one line_drawer
// Ports:
//   clk          : clock
//   reset_n      : synchronous, active-low reset
//   update_event : one-cycle request to advance one step (queued when busy)
//   enable       : low holds the block in S_WAIT; a queued update is kept
//   x, y         : pixel coordinate, 0 when pixel_valid is low
//   pixel_color  : 1 draw, 0 erase
//   pixel_valid  : framebuffer write strobe
//   frame_done   : one-cycle pulse when every line has been drawn at a step
//   step         : current animation step
module line_animator_multi
    import line_anim_pkg::*;
#(
    parameter int COORD_W   = 11,
    parameter int NUM_LINES = 2,
    parameter int STEPS     = 128,
    parameter int DX        = 1,
    parameter int DY        = 1,
    parameter int LEN_X     = 10,
    parameter int LEN_Y     = 15,
    parameter int SPACE_X   = 0,
    parameter int SPACE_Y   = 20,
    parameter int BASE_X    = 0,
    parameter int BASE_Y    = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     update_event,
    input  logic                     enable,
    output logic [COORD_W-1:0]       x,
    output logic [COORD_W-1:0]       y,
    output logic                     pixel_color,
    output logic                     pixel_valid,
    output logic                     frame_done,
    output logic [$clog2(STEPS)-1:0] step
);

    localparam int STEP_W = $clog2(STEPS);
    localparam int IDX_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               pending_q, pending_d;

    logic               run_valid, run_color, run_done;
    logic               accept;

    logic [COORD_W-1:0] lx0, ly0, lx1, ly1;
    logic [COORD_W-1:0] dr_x, dr_y;
    logic               dr_finished;
    logic               dr_reset;

    // Endpoints of line idx at the current step; they only change while the
    // drawer is being loaded, so they are stable for the whole walk.
    assign lx0 = COORD_W'(line_coord(32'(idx_q), 32'(step_q), BASE_X, SPACE_X, DX, 0));
    assign ly0 = COORD_W'(line_coord(32'(idx_q), 32'(step_q), BASE_Y, SPACE_Y, DY, 0));
    assign lx1 = COORD_W'(line_coord(32'(idx_q), 32'(step_q), BASE_X, SPACE_X, DX, LEN_X));
    assign ly1 = COORD_W'(line_coord(32'(idx_q), 32'(step_q), BASE_Y, SPACE_Y, DY, LEN_Y));

    assign dr_reset = ~reset_n | (state_q == S_LOAD);

    line_drawer #(
        .COORD_W (COORD_W)
    ) u_drawer (
        .clk      (clk),
        .reset    (dr_reset),
        .x0       (lx0),
        .y0       (ly0),
        .x1       (lx1),
        .y1       (ly1),
        .x        (dr_x),
        .y        (dr_y),
        .finished (dr_finished)
    );

    assign accept = (state_q == S_WAIT) && (update_event || pending_q) && enable;

    // An acceptance swallows a pulse arriving in the same cycle; any other
    // pulse, including one in the frame_done cycle, is remembered.
    assign pending_d = accept ? 1'b0 : (pending_q | update_event);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        step_d    = step_q;
        run_valid = 1'b0;
        run_color = 1'b0;
        run_done  = 1'b0;
        case (state_q)
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                run_valid = 1'b1;
                run_color = (phase_q == PH_DRAW);
                if (dr_finished) begin
                    if (idx_q != IDX_W'(NUM_LINES - 1)) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_LOAD;
                    end else if (phase_q == PH_ERASE) begin
                        // The erase pass ran at the old step; only now move on.
                        idx_d   = '0;
                        phase_d = PH_DRAW;
                        step_d  = (step_q == STEP_W'(STEPS - 1)) ? '0 : step_q + STEP_W'(1);
                        state_d = S_LOAD;
                    end else begin
                        run_done = 1'b1;
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (accept) begin
                    idx_d   = '0;
                    phase_d = PH_ERASE;
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_LOAD;
            phase_q   <= PH_DRAW;
            idx_q     <= '0;
            step_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            step_q    <= step_d;
            pending_q <= pending_d;
        end
    end

    // Outputs are masked by reset_n so they read 0 while reset is held,
    // even before the first clock edge has loaded the state registers.
    assign pixel_valid = run_valid & reset_n;
    assign pixel_color = run_color & reset_n;
    assign frame_done  = run_done & reset_n;
    assign x           = pixel_valid ? dr_x : '0;
    assign y           = pixel_valid ? dr_y : '0;
    assign step        = reset_n ? step_q : '0;

endmodule

// File: tb/tb_line_animator_multi.sv
// tb/tb_line_animator_multi.sv - directed self-checking bench for line_animator_multi
module tb_line_animator_multi;

    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          update_event;
    logic          enable;
    logic [CW-1:0] x, y;
    logic          pixel_color, pixel_valid, frame_done;
    logic [1:0]    step;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    line_animator_multi #(
        .COORD_W (CW),
        .STEPS   (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .update_event (update_event),
        .enable       (enable),
        .x            (x),
        .y            (y),
        .pixel_color  (pixel_color),
        .pixel_valid  (pixel_valid),
        .frame_done   (frame_done),
        .step         (step)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_update();
        update_event = 1'b1;
        @(negedge clk);
        update_event = 1'b0;
    endtask

    // Waits for the next run of valid pixels and checks it as one line:
    // start, end, pixel count, colour and frame_done pulses. With pulse set,
    // update_event is raised on the 2nd and 4th pixel cycles of the line.
    task automatic collect(input string tag, input int ex0, input int ey0,
                           input int ex1, input int ey1, input logic color,
                           input int exp_fd, input logic pulse, output int lat);
        int n, fd, fx, fy, lx, ly, bad_color;
        n = 0; fd = 0; bad_color = 0; lat = 0;
        fx = 0; fy = 0; lx = 0; ly = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!pixel_valid && lat < 200);
        if (!pixel_valid) begin
            chk({tag, ".timeout"}, 32'd0, 32'd1);
            return;
        end
        fx = int'(x);
        fy = int'(y);
        while (pixel_valid && n < 200) begin
            n++;
            lx = int'(x);
            ly = int'(y);
            if (pixel_color !== color) bad_color++;
            if (frame_done === 1'b1) fd++;
            update_event = pulse && (n == 2 || n == 4);
            @(negedge clk);
        end
        update_event = 1'b0;
        chk({tag, ".x0"}, fx, ex0);
        chk({tag, ".y0"}, fy, ey0);
        chk({tag, ".x1"}, lx, ex1);
        chk({tag, ".y1"}, ly, ey1);
        chk({tag, ".count"}, n, 16);
        chk({tag, ".bad_color"}, bad_color, 0);
        chk({tag, ".frame_done"}, fd, exp_fd);
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (pixel_valid !== 1'b0) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        int lat;
        reset_n      = 1'b0;
        update_event = 1'b0;
        enable       = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.valid", pixel_valid, 0);
        chk("rst.x", x, 0);
        chk("rst.y", y, 0);
        chk("rst.color", pixel_color, 0);
        chk("rst.frame_done", frame_done, 0);
        chk("rst.step", step, 0);

        // release: one dead S_LOAD cycle, then the first pixel
        reset_n = 1'b1;
        #1;
        chk("dead.valid", pixel_valid, 0);
        chk("dead.step", step, 0);
        collect("s0.d0", 0, 0, 10, 15, 1'b1, 0, 1'b0, lat);
        chk("s0.d0.lat", lat, 1);
        collect("s0.d1", 0, 20, 10, 35, 1'b1, 1, 1'b0, lat);
        chk("s0.wait.valid", pixel_valid, 0);
        chk("s0.step", step, 0);

        // one update: erase at step 0, then draw at step 1
        pulse_update();
        chk("upd.load.valid", pixel_valid, 0);
        collect("s1.e0", 0, 0, 10, 15, 1'b0, 0, 1'b0, lat);
        chk("s1.e0.lat", lat, 1);
        collect("s1.e1", 0, 20, 10, 35, 1'b0, 0, 1'b0, lat);
        chk("s1.step_after_erase", step, 1);
        collect("s1.d0", 1, 1, 11, 16, 1'b1, 0, 1'b0, lat);
        collect("s1.d1", 1, 21, 11, 36, 1'b1, 1, 1'b0, lat);
        chk("s1.step", step, 1);

        // advance to step 2, two extra pulses while drawing -> one queued advance
        pulse_update();
        collect("s2.e0", 1, 1, 11, 16, 1'b0, 0, 1'b0, lat);
        collect("s2.e1", 1, 21, 11, 36, 1'b0, 0, 1'b0, lat);
        collect("s2.d0", 2, 2, 12, 17, 1'b1, 0, 1'b1, lat);
        collect("s2.d1", 2, 22, 12, 37, 1'b1, 1, 1'b0, lat);
        chk("s2.step", step, 2);
        collect("s3.e0", 2, 2, 12, 17, 1'b0, 0, 1'b0, lat);
        chk("s3.e0.lat", lat, 2);
        collect("s3.e1", 2, 22, 12, 37, 1'b0, 0, 1'b0, lat);
        collect("s3.d0", 3, 3, 13, 18, 1'b1, 0, 1'b0, lat);
        collect("s3.d1", 3, 23, 13, 38, 1'b1, 1, 1'b0, lat);
        chk("s3.step", step, 3);
        idle_check("s3.idle", 20);

        // fourth update wraps to step 0
        pulse_update();
        collect("s4.e0", 3, 3, 13, 18, 1'b0, 0, 1'b0, lat);
        collect("s4.e1", 3, 23, 13, 38, 1'b0, 0, 1'b0, lat);
        collect("s4.d0", 0, 0, 10, 15, 1'b1, 0, 1'b0, lat);
        collect("s4.d1", 0, 20, 10, 35, 1'b1, 1, 1'b0, lat);
        chk("s4.step_wrap", step, 0);

        // pause: update held while enable is low
        enable = 1'b0;
        pulse_update();
        idle_check("pause.idle", 10);
        enable = 1'b1;
        collect("en.e0", 0, 0, 10, 15, 1'b0, 0, 1'b0, lat);
        chk("en.e0.lat", lat, 2);
        collect("en.e1", 0, 20, 10, 35, 1'b0, 0, 1'b0, lat);
        collect("en.d0", 1, 1, 11, 16, 1'b1, 0, 1'b0, lat);
        collect("en.d1", 1, 21, 11, 36, 1'b1, 1, 1'b0, lat);
        chk("en.step", step, 1);

        // reset in the middle of an erase; a pulse during reset is dropped
        pulse_update();
        collect("mr.e0", 1, 1, 11, 16, 1'b0, 0, 1'b0, lat);
        @(negedge clk);
        chk("mr.e1.valid", pixel_valid, 1);
        chk("mr.e1.color", pixel_color, 0);
        chk("mr.e1.y", y, 21);
        reset_n      = 1'b0;
        update_event = 1'b1;
        #1;
        chk("mr.low.valid", pixel_valid, 0);
        @(negedge clk);
        update_event = 1'b0;
        chk("mr.low.step", step, 0);
        reset_n = 1'b1;
        collect("mr.d0", 0, 0, 10, 15, 1'b1, 0, 1'b0, lat);
        chk("mr.d0.lat", lat, 1);
        collect("mr.d1", 0, 20, 10, 35, 1'b1, 1, 1'b0, lat);
        chk("mr.step", step, 0);
        idle_check("mr.idle", 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
